// File: rtl/d_latch_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : d_latch_write_sequencer
// Description : Drives a mux-based D latch with a setup / enable / hold
//               sequence for each accepted bit. Reads back q after hold,
//               flags mismatches and keeps a saturating error count.
// Revision    : 1.0 - initial release
// ============================================================================
module d_latch_write_sequencer #(
    parameter int SETUP_CYC = 2,
    parameter int EN_CYC    = 3,
    parameter int HOLD_CYC  = 1,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_data,
    output logic       in_ready,
    output logic       latch_d,
    output logic       latch_en,
    input  logic       latch_q,
    input  logic       err_clr,
    output logic       done,
    output logic       err,
    output logic [7:0] err_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_ENABLE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;

    localparam logic [CNT_W-1:0] c_SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] c_EN_LAST    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] c_HOLD_LAST  = CNT_W'(HOLD_CYC - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_latch_d;
    logic             r_latch_en;
    logic             r_readback;
    logic [7:0]       r_err_count;
    logic             w_accept;
    logic             w_check;
    logic             w_err;

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_check  = (r_state == S_CHECK);
    assign w_err    = w_check && (r_readback != r_latch_d);

    // Next-state decode: each timed phase ends when its counter hits the last index
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (in_valid)              w_next_state = S_SETUP;
            S_SETUP:  if (r_cnt == c_SETUP_LAST) w_next_state = S_ENABLE;
            S_ENABLE: if (r_cnt == c_EN_LAST)    w_next_state = S_HOLD;
            S_HOLD:   if (r_cnt == c_HOLD_LAST)  w_next_state = S_CHECK;
            S_CHECK:                             w_next_state = S_IDLE;
            default:                             w_next_state = S_IDLE;
        endcase
    end

    // State register and phase counter; counter restarts at 0 on every state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if ((w_next_state != r_state) || (r_state == S_IDLE))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
        end
    end

    // Registered latch pins and handshake: en/ready are decoded from the next
    // state so they toggle cleanly on the same edge as the state change, and
    // d only moves on the accept edge (when en is guaranteed low)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready <= 1'b1;
            r_latch_en <= 1'b0;
            r_latch_d  <= 1'b0;
            r_readback <= 1'b0;
        end else begin
            r_in_ready <= (w_next_state == S_IDLE);
            r_latch_en <= (w_next_state == S_ENABLE);
            if (w_accept)
                r_latch_d <= in_data;
            if ((r_state == S_HOLD) && (w_next_state == S_CHECK))
                r_readback <= latch_q;
        end
    end

    // Saturating mismatch counter; clear wins over a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_err_count <= 8'd0;
        else if (err_clr)
            r_err_count <= 8'd0;
        else if (w_err && (r_err_count != 8'hFF))
            r_err_count <= r_err_count + 8'd1;
    end

    assign in_ready  = r_in_ready;
    assign latch_d   = r_latch_d;
    assign latch_en  = r_latch_en;
    assign done      = w_check;
    assign err       = w_err;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_d_latch_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_d_latch_write_sequencer
// Description : Self-checking bench for d_latch_write_sequencer with a
//               behavioural latch and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_d_latch_write_sequencer;

    localparam int c_S   = 2;
    localparam int c_E   = 3;
    localparam int c_H   = 1;
    localparam int c_TXN = c_S + c_E + c_H + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_data = 1'b0;
    logic       in_ready;
    logic       latch_d;
    logic       latch_en;
    logic       latch_q;
    logic       err_clr = 1'b0;
    logic       done;
    logic       err;
    logic [7:0] err_count;

    int total = 0;
    int bad   = 0;

    d_latch_write_sequencer #(
        .SETUP_CYC (c_S),
        .EN_CYC    (c_E),
        .HOLD_CYC  (c_H),
        .CNT_W     (4)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .latch_d   (latch_d),
        .latch_en  (latch_en),
        .latch_q   (latch_q),
        .err_clr   (err_clr),
        .done      (done),
        .err       (err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // Behavioural transparent latch with an optional stuck-at fault on q
    logic lat_q     = 1'b0;
    logic stuck     = 1'b0;
    logic stuck_val = 1'b0;
    always @(latch_en or latch_d) if (latch_en) lat_q = latch_d;
    assign latch_q = stuck ? stuck_val : lat_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_k is the 1-based cycle index inside a transaction (0 = idle)
    int   m_k   = 0;
    logic m_d   = 1'b0;
    int   m_cnt = 0;

    function automatic logic m_mismatch();
        logic rb;
        rb = stuck ? stuck_val : m_d;
        return rb != m_d;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k = 0; m_d = 1'b0; m_cnt = 0;
        end else begin
            if (err_clr) m_cnt = 0;
            else if (m_k == c_TXN && m_mismatch() && m_cnt < 255) m_cnt = m_cnt + 1;
            if (m_k == 0) begin
                if (in_valid) begin m_k = 1; m_d = in_data; end
            end else if (m_k == c_TXN) m_k = 0;
            else m_k = m_k + 1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            chk("m_in_ready",  {31'd0, in_ready},  {31'd0, m_k == 0});
            chk("m_latch_en",  {31'd0, latch_en},  {31'd0, (m_k >= c_S + 1) && (m_k <= c_S + c_E)});
            chk("m_latch_d",   {31'd0, latch_d},   {31'd0, m_d});
            chk("m_done",      {31'd0, done},      {31'd0, m_k == c_TXN});
            chk("m_err",       {31'd0, err},       {31'd0, (m_k == c_TXN) && m_mismatch()});
            chk("m_err_count", {24'd0, err_count}, m_cnt);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One full write from idle; optionally pulse err_clr during the CHECK cycle
    task automatic write_bit(input logic b, input logic clr_at_check);
        in_data = b; in_valid = 1'b1;
        cyc(1);
        in_valid = 1'b0;
        cyc(c_TXN - 1);
        chk("wr_done", {31'd0, done}, 32'd1);
        err_clr = clr_at_check;
        cyc(1);
        err_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        cyc(2);
        rst = 1'b0;
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_en",    {31'd0, latch_en}, 32'd0);
        chk("rst_d",     {31'd0, latch_d},  32'd0);
        chk("rst_cnt",   {24'd0, err_count}, 32'd0);
        cyc(1);

        // Write 1, good latch: en high in cycles 3..5, done in cycle 7
        in_data = 1'b1; in_valid = 1'b1;
        cyc(1);
        in_valid = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            chk("t2_en", {31'd0, latch_en}, {31'd0, (lat >= 3) && (lat <= 5)});
            cyc(1);
            lat++;
        end
        chk("t2_latency", lat, 32'd7);
        chk("t2_err", {31'd0, err}, 32'd0);
        cyc(1);
        chk("t2_ready_after", {31'd0, in_ready}, 32'd1);

        // Back-to-back 0 then 1 with in_valid held
        in_data = 1'b0; in_valid = 1'b1;
        cyc(1);
        in_data = 1'b1;
        cyc(6);
        chk("t3_done0", {31'd0, done},    32'd1);
        chk("t3_q0",    {31'd0, latch_q}, 32'd0);
        chk("t3_err0",  {31'd0, err},     32'd0);
        cyc(2);
        in_valid = 1'b0;
        chk("t3_second_accept", {31'd0, in_ready}, 32'd0);
        chk("t3_d1", {31'd0, latch_d}, 32'd1);
        cyc(6);
        chk("t3_done1", {31'd0, done},    32'd1);
        chk("t3_q1",    {31'd0, latch_q}, 32'd1);
        chk("t3_err1",  {31'd0, err},     32'd0);
        cyc(1);

        // Stuck q=0: every write of 1 mismatches; counter saturates
        stuck = 1'b1; stuck_val = 1'b0;
        write_bit(1'b1, 1'b0);
        chk("t4_cnt1", {24'd0, err_count}, 32'd1);
        for (int i = 1; i < 300; i++) write_bit(1'b1, 1'b0);
        chk("t4_sat", {24'd0, err_count}, 32'd255);

        // Clear coincident with an increment wins
        write_bit(1'b1, 1'b1);
        chk("t5_clr", {24'd0, err_count}, 32'd0);
        write_bit(1'b1, 1'b0);
        chk("t5_inc_after", {24'd0, err_count}, 32'd1);

        // in_valid pulses while busy are ignored
        stuck = 1'b0;
        in_data = 1'b1; in_valid = 1'b1;
        cyc(1);
        for (int k = 1; k < c_TXN; k++) begin
            in_valid = k[0];
            in_data  = 1'b0;
            cyc(1);
        end
        in_valid = 1'b0;
        chk("t6_done", {31'd0, done},    32'd1);
        chk("t6_err",  {31'd0, err},     32'd0);
        chk("t6_d",    {31'd0, latch_d}, 32'd1);
        cyc(1);
        chk("t6_idle_d", {31'd0, latch_d}, 32'd1);
        cyc(1);
        chk("t6_no_queue", {31'd0, in_ready}, 32'd1);

        // Async reset in the middle of ENABLE
        in_data = 1'b1; in_valid = 1'b1;
        cyc(1);
        in_valid = 1'b0;
        cyc(3);
        chk("t1_en_before", {31'd0, latch_en}, 32'd1);
        chk("t1_cnt_before", {24'd0, err_count}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t1_en",    {31'd0, latch_en},  32'd0);
        chk("t1_ready", {31'd0, in_ready},  32'd1);
        chk("t1_d",     {31'd0, latch_d},   32'd0);
        chk("t1_cnt",   {24'd0, err_count}, 32'd0);
        cyc(1);
        rst = 1'b0;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
